// File: rtl/aer_pkg.sv
// Shared types and constants for the AER spike encoder.
// AER_TIMESTAMP_EN adds a timestamp field to the FIFO entry.
package aer_pkg;

  localparam int AER_TS_W       = 8;
  // Widest source index the entry can carry (up to 256 sources).
  localparam int AER_ADDR_W_MAX = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } aer_state_e;

  typedef struct packed {
`ifdef AER_TIMESTAMP_EN
    logic [AER_TS_W-1:0]       ts;
`endif
    logic [AER_ADDR_W_MAX-1:0] addr;
  } aer_entry_t;

endpackage

// File: rtl/aer_spike_encoder_if.sv
// 4-phase AER output bus: request/address (+timestamp) out, acknowledge back.
// aer_ts exists only when AER_TIMESTAMP_EN is defined.
interface aer_spike_encoder_if #(
  parameter int ADDR_W = 2
);

  logic              aer_req;
  logic              aer_ack;
  logic [ADDR_W-1:0] aer_addr;
`ifdef AER_TIMESTAMP_EN
  logic [aer_pkg::AER_TS_W-1:0] aer_ts;
`endif

  modport master (
    output aer_req,
    output aer_addr,
`ifdef AER_TIMESTAMP_EN
    output aer_ts,
`endif
    input  aer_ack
  );

  modport slave (
    input  aer_req,
    input  aer_addr,
`ifdef AER_TIMESTAMP_EN
    input  aer_ts,
`endif
    output aer_ack
  );

endinterface

// File: rtl/aer_fifo.sv
// Event FIFO: power-of-two depth, combinational read of the head entry,
// simultaneous push and pop allowed at any occupancy.
module aer_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot being written, so a full FIFO still accepts push+pop.
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  // NOTE: storage has no reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: flops use <= so every register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Power-of-two depth makes the pointers wrap on natural overflow.
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/aer_spike_encoder.sv
// Rising-edge spike detector, per-source pending latches, lowest-index arbiter,
// event FIFO and 4-phase AER handshake. AER_TIMESTAMP_EN adds ts_cnt and aer_ts.
module aer_spike_encoder
  import aer_pkg::*;
#(
  parameter int  N_SRC      = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int ADDR_W     = $clog2(N_SRC),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC-1:0]           spike_in,
  aer_spike_encoder_if.master        aer,
  output logic                       overflow,
  output logic [LVL_W-1:0]           fifo_level
);

  logic [N_SRC-1:0]  spike_q;
  logic [N_SRC-1:0]  spike_edge;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [N_SRC-1:0]  clr_mask;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] push_idx;
  logic              push_hit, do_push, do_pop;
  logic              fifo_full, fifo_empty;
  aer_entry_t        push_entry, pop_entry;
  logic              ack_meta_q, ack_s_q;
  aer_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              unused_entry_bits;

  // ---------------------------------------------------------------- capture
  assign spike_edge = spike_in & ~spike_q;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    push_idx = '0;
    push_hit = 1'b0;
    // Scanning downwards leaves the lowest set index as the final assignment.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        push_idx = ADDR_W'(i);
        push_hit = 1'b1;
      end
    end
  end

  assign do_push  = push_hit & ~fifo_full;
  assign clr_mask = do_push ? (N_SRC'(1) << push_idx) : '0;
  // OR-ing the edge in after the clear lets a same-cycle set win.
  assign pend_d     = (pend_q & ~clr_mask) | spike_edge;
  assign overflow_d = overflow_q | (|(spike_edge & pend_q & ~clr_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q    <= '0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      spike_q    <= spike_in;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifdef AER_TIMESTAMP_EN
  logic [AER_TS_W-1:0] ts_cnt_q;
  logic [AER_TS_W-1:0] ts_q, ts_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt_q <= '0;
    else        ts_cnt_q <= ts_cnt_q + AER_TS_W'(1);
  end
`endif

  always_comb begin
    push_entry      = '0;
    push_entry.addr = AER_ADDR_W_MAX'(push_idx);
`ifdef AER_TIMESTAMP_EN
    push_entry.ts   = ts_cnt_q;
`endif
  end

  // ------------------------------------------------------------------- FIFO
  aer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(aer_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (do_push),
    .wdata_i (push_entry),
    .pop_i   (do_pop),
    .rdata_o (pop_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Only the low ADDR_W address bits are meaningful for this N_SRC.
  assign unused_entry_bits = ^pop_entry.addr;

  // -------------------------------------------------------------- handshake
  // aer_ack comes from another timing domain; two flops before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= aer.aer_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    do_pop  = 1'b0;
`ifdef AER_TIMESTAMP_EN
    ts_d    = ts_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          do_pop  = 1'b1;
          addr_d  = pop_entry.addr[ADDR_W-1:0];
`ifdef AER_TIMESTAMP_EN
          ts_d    = pop_entry.ts;
`endif
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s_q) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Address stays put until the consumer has dropped its acknowledge.
        if (!ack_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
`ifdef AER_TIMESTAMP_EN
      ts_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
`ifdef AER_TIMESTAMP_EN
      ts_q    <= ts_d;
`endif
    end
  end

  assign aer.aer_req  = req_q;
  assign aer.aer_addr = addr_q;
`ifdef AER_TIMESTAMP_EN
  assign aer.aer_ts   = ts_q;
`endif

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench for aer_spike_encoder: stimulus queues expected events,
// a monitor pops and compares on every aer_req rising edge.
`timescale 1ns/1ps
module tb_aer_spike_encoder;
  import aer_pkg::*;

  localparam int N_SRC      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 2;
  localparam int LVL_W      = 3;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        ts;
    bit                ts_chk;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_SRC-1:0] spike_in = '0;
  logic             overflow;
  logic [LVL_W-1:0] fifo_level;
  logic             ack_en = 1'b0;
  logic [1:0]       ack_pipe;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_hs  = 0;
  exp_t exp_q[$];

  aer_spike_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  aer_spike_encoder #(
    .N_SRC      (N_SRC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .aer        (bus),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Consumer: acknowledge is aer_req delayed by two cycles, gated by ack_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_pipe <= '0;
    else        ack_pipe <= {ack_pipe[0], bus.aer_req};
  end
  assign bus.aer_ack = ack_en & ack_pipe[1];

`ifdef AER_TIMESTAMP_EN
  logic [7:0] tb_ts;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 8'd1;
  end
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [ADDR_W-1:0] a, input logic [7:0] t, input bit c);
    exp_t e;
    e.addr = a;
    e.ts = t;
    e.ts_chk = c;
    return e;
  endfunction

  // Monitor: compare each offered event with the head of the scoreboard.
  logic              req_prev = 1'b0;
  logic [ADDR_W-1:0] hs_addr  = '0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (bus.aer_req && !req_prev) begin
        n_hs++;
        hs_addr = bus.aer_addr;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got addr %0d, expected no event", bus.aer_addr);
        end else begin
          e = exp_q.pop_front();
          check("aer_addr", 32'(bus.aer_addr), 32'(e.addr));
`ifdef AER_TIMESTAMP_EN
          if (e.ts_chk) check("aer_ts", 32'(bus.aer_ts), 32'(e.ts));
`endif
        end
      end
      if (!bus.aer_req && req_prev) check("addr_stable", 32'(bus.aer_addr), 32'(hs_addr));
    end
    req_prev = bus.aer_req;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || bus.aer_req || fifo_level != '0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    tick(12);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [N_SRC-1:0] full_vec [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000,
                                      4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};

  initial begin : stimulus
    int hs0;

    // Reset state, checked while rst_n is still low.
    @(negedge clk);
    check("rst_req",   32'(bus.aer_req),  32'd0);
    check("rst_addr",  32'(bus.aer_addr), 32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
    check("rst_level", 32'(fifo_level),   32'd0);
    tick(2);
    rst_n = 1'b1;
    ack_en = 1'b1;
    tick(2);

    // Single spike: request rises two clocks after the edge is sampled.
    hs0 = n_hs;
    @(negedge clk); spike_in = 4'b0001; exp_q.push_back(mk(2'd0, 8'd0, 1'b0));
    @(negedge clk); spike_in = 4'b0000; check("lat_k0", 32'(bus.aer_req), 32'd0);
    @(negedge clk); check("lat_k1", 32'(bus.aer_req), 32'd0);
    @(negedge clk); check("lat_k2", 32'(bus.aer_req), 32'd1);
    wait_idle("single");
    check("single_hs_count", 32'(n_hs - hs0), 32'd1);
    check("single_ovf", 32'(overflow), 32'd0);

    // Simultaneous spikes with ack withheld: level peaks at 3.
    ack_en = 1'b0;
    @(negedge clk); spike_in = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(ADDR_W'(i), 8'd0, 1'b0));
    @(negedge clk); spike_in = 4'b0000;
    tick(4);
    check("simul_level_peak", 32'(fifo_level), 32'd3);
    tick(4);
    check("simul_level_hold", 32'(fifo_level), 32'd3);
    ack_en = 1'b1;
    wait_idle("simul");
    check("simul_ovf", 32'(overflow), 32'd0);

    // Held level: a single event only.
    hs0 = n_hs;
    @(negedge clk); spike_in = 4'b0100; exp_q.push_back(mk(2'd2, 8'd0, 1'b0));
    tick(20);
    spike_in = 4'b0000;
    wait_idle("held");
    check("held_hs_count", 32'(n_hs - hs0), 32'd1);

    // FIFO full: retained pending bit, then a merged edge sets overflow.
    ack_en = 1'b0;
    exp_q.push_back(mk(2'd0, 8'd0, 1'b0));
    exp_q.push_back(mk(2'd1, 8'd0, 1'b0));
    exp_q.push_back(mk(2'd2, 8'd0, 1'b0));
    exp_q.push_back(mk(2'd3, 8'd0, 1'b0));
    exp_q.push_back(mk(2'd0, 8'd0, 1'b0));
    exp_q.push_back(mk(2'd0, 8'd0, 1'b0));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      spike_in = full_vec[c];
      if (c == 6) begin
        check("full_level3", 32'(fifo_level),  32'd3);
        check("full_req",    32'(bus.aer_req), 32'd1);
      end
      if (c == 10) begin
        check("full_level4",      32'(fifo_level), 32'd4);
        check("full_retain_ovf0", 32'(overflow),   32'd0);
      end
      if (c == 11) check("full_merge_ovf1", 32'(overflow), 32'd1);
    end
    ack_en = 1'b1;
    wait_idle("full");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the REQ state with two entries queued.
    ack_en = 1'b0;
    @(negedge clk); spike_in = 4'b0111; exp_q.push_back(mk(2'd0, 8'd0, 1'b0));
    @(negedge clk); spike_in = 4'b0000;
    tick(3);
    check("pre_rst_level", 32'(fifo_level),  32'd2);
    check("pre_rst_state", 32'(dut.state_q), 32'(REQ));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req",   32'(bus.aer_req),  32'd0);
    check("async_rst_level", 32'(fifo_level),   32'd0);
    check("async_rst_state", 32'(dut.state_q),  32'(IDLE));
    check("async_rst_ovf",   32'(overflow),     32'd0);
    tick(2);
    rst_n = 1'b1;
    ack_en = 1'b1;
    hs0 = n_hs;
    tick(30);
    check("post_rst_no_event", 32'(n_hs - hs0),  32'd0);
    check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef AER_TIMESTAMP_EN
    // Timestamps across the counter wrap.
    begin : ts_test
      int cyc;
      cyc = 0;
      while (tb_ts != 8'd253 && cyc < 300) begin @(negedge clk); cyc++; end
      check("ts_wait_253", 32'(tb_ts), 32'd253);
      spike_in = 4'b0001; exp_q.push_back(mk(2'd0, 8'd254, 1'b1));
      @(negedge clk); spike_in = 4'b0000;
      cyc = 0;
      while (tb_ts != 8'd0 && cyc < 300) begin @(negedge clk); cyc++; end
      check("ts_wait_0", 32'(tb_ts), 32'd0);
      spike_in = 4'b0010; exp_q.push_back(mk(2'd1, 8'd1, 1'b1));
      @(negedge clk); spike_in = 4'b0000;
      wait_idle("ts");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
